// File: rtl/maze_pkg.sv
// Shared definitions for the maze grid memory and the solver that talks to it.
// Cell encoding, FSM states, default geometry and direction codes.
package maze_pkg;

  localparam int ROWS_DEF = 64;
  localparam int COLS_DEF = 64;
  localparam int AW_DEF   = 6;

  localparam logic [1:0] CELL_FREE = 2'b00;
  localparam logic [1:0] CELL_WALL = 2'b01;
  localparam logic [1:0] CELL_PATH = 2'b10;

  typedef enum logic [1:0] {CLEAR, READY, DUMP} state_t;

  typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_t;

  function automatic logic in_range(input int r, input int c, input int rows, input int cols);
    return (r < rows) && (c < cols);
  endfunction

endpackage

// File: rtl/maze_scan_ctr.sv
// Row/column sweep counter: steps a whole row (clear sweep) or one cell (dump scan),
// wrapping to (0,0) after the last position.
module maze_scan_ctr #(
  parameter int ROWS = 64,
  parameter int COLS = 64,
  parameter int AW   = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          row_step,
  input  logic          cell_step,
  output logic [AW-1:0] row,
  output logic [AW-1:0] col,
  output logic          last_row,
  output logic          last_cell
);

  localparam logic [AW-1:0] ROW_MAX = AW'(ROWS - 1);
  localparam logic [AW-1:0] COL_MAX = AW'(COLS - 1);

  assign last_row  = (row == ROW_MAX);
  assign last_cell = last_row && (col == COL_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (row_step) begin
      col <= '0;
      row <= last_row ? '0 : row + 1'b1;
    end else if (cell_step) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/maze_memory.sv
// Maze grid responder: wall/path bit per cell, solver read/mark port, host load port,
// row-sweep clear and row-major dump stream.
//
//   state | meaning
//   CLEAR | zero one row per cycle, status counters reset; busy
//   READY | serve solver reads/marks and host loads
//   DUMP  | stream one cell per cycle row-major; busy
module maze_memory import maze_pkg::*; #(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] row,
  input  logic [AW-1:0] col,
  input  logic          maze_oe,
  input  logic          maze_we,
  output logic          maze_in,
  input  logic          load_en,
  input  logic [AW-1:0] load_row,
  input  logic [AW-1:0] load_col,
  input  logic          load_wall,
  input  logic          clear_req,
  input  logic          dump_req,
  output logic          busy,
  output logic          dump_valid,
  output logic [AW-1:0] dump_row,
  output logic [AW-1:0] dump_col,
  output logic [1:0]    dump_cell,
  output logic          dump_done,
  output logic [12:0]   path_count,
  output logic          err_wall_write
);

  state_t state, state_nxt;

  logic [AW-1:0] scan_row, scan_col;
  logic          scan_last_row, scan_last_cell;
  logic          scan_clr, scan_row_step, scan_cell_step;
  logic          ready;

  logic [COLS-1:0] wall_mem [ROWS];
  logic [COLS-1:0] path_mem [ROWS];

  logic sel_ok, sel_wall, sel_path;
  logic ld_ok, ld_dec, same_cell;
  logic we_act, we_set, we_err;

  maze_scan_ctr #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) u_scan (
    .clk       (clk),
    .rst       (rst),
    .clr       (scan_clr),
    .row_step  (scan_row_step),
    .cell_step (scan_cell_step),
    .row       (scan_row),
    .col       (scan_col),
    .last_row  (scan_last_row),
    .last_cell (scan_last_cell)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (scan_last_row) state_nxt = READY;
      READY: begin
        if (clear_req)     state_nxt = CLEAR;
        else if (dump_req) state_nxt = DUMP;
      end
      DUMP:    if (scan_last_cell) state_nxt = READY;
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    busy           = 1'b1;
    ready          = 1'b0;
    scan_clr       = 1'b0;
    scan_row_step  = 1'b0;
    scan_cell_step = 1'b0;
    dump_valid     = 1'b0;
    dump_done      = 1'b0;
    dump_row       = '0;
    dump_col       = '0;
    dump_cell      = CELL_FREE;
    case (state)
      CLEAR: scan_row_step = 1'b1;
      READY: begin
        busy     = 1'b0;
        ready    = 1'b1;
        scan_clr = 1'b1;
      end
      DUMP: begin
        scan_cell_step = 1'b1;
        dump_valid     = 1'b1;
        dump_done      = scan_last_cell;
        dump_row       = scan_row;
        dump_col       = scan_col;
        dump_cell      = {path_mem[scan_row][scan_col], wall_mem[scan_row][scan_col]};
      end
      default: ;
    endcase
  end

  // A host load on the cell the solver is marking wins; the mark is dropped.
  always_comb begin
    sel_ok    = in_range(int'(row), int'(col), ROWS, COLS);
    sel_wall  = sel_ok ? wall_mem[row][col] : 1'b1;
    sel_path  = sel_ok ? path_mem[row][col] : 1'b0;
    ld_ok     = ready & load_en & in_range(int'(load_row), int'(load_col), ROWS, COLS);
    ld_dec    = ld_ok ? path_mem[load_row][load_col] : 1'b0;
    same_cell = ld_ok & (load_row == row) & (load_col == col);
    we_act    = ready & maze_we & ~same_cell;
    we_set    = we_act & ~sel_wall & ~sel_path;
    we_err    = we_act & sel_wall;
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      wall_mem[scan_row] <= '0;
      path_mem[scan_row] <= '0;
    end else begin
      if (we_set) path_mem[row][col] <= 1'b1;
      if (ld_ok) begin
        wall_mem[load_row][load_col] <= load_wall;
        path_mem[load_row][load_col] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      maze_in        <= 1'b0;
      path_count     <= '0;
      err_wall_write <= 1'b0;
    end else begin
      if (ready & maze_oe) maze_in <= sel_wall;
      if (ready & clear_req) begin
        path_count     <= '0;
        err_wall_write <= 1'b0;
      end else begin
        if (we_err) err_wall_write <= 1'b1;
        case ({we_set, ld_dec})
          2'b10:   path_count <= path_count + 13'd1;
          2'b01:   path_count <= path_count - 13'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_maze_memory.sv
// Directed bench for maze_memory: cell-level reference model plus literal spot checks.
module tb_maze_memory;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  row = '0, col = '0;
  logic        maze_oe = 1'b0, maze_we = 1'b0;
  logic        maze_in;
  logic        load_en = 1'b0;
  logic [5:0]  load_row = '0, load_col = '0;
  logic        load_wall = 1'b0;
  logic        clear_req = 1'b0, dump_req = 1'b0;
  logic        busy, dump_valid, dump_done, err_wall_write;
  logic [5:0]  dump_row, dump_col;
  logic [1:0]  dump_cell;
  logic [12:0] path_count;

  maze_memory dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .maze_oe(maze_oe), .maze_we(maze_we),
    .maze_in(maze_in), .load_en(load_en), .load_row(load_row), .load_col(load_col),
    .load_wall(load_wall), .clear_req(clear_req), .dump_req(dump_req), .busy(busy),
    .dump_valid(dump_valid), .dump_row(dump_row), .dump_col(dump_col), .dump_cell(dump_cell),
    .dump_done(dump_done), .path_count(path_count), .err_wall_write(err_wall_write)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  bit m_wall [64][64];
  bit m_path [64][64];
  int m_count;
  bit m_err, m_in;

  bit mon_ready = 1'b0, mon_dump = 1'b0;
  int d_idx, d_done_cnt;
  logic [1:0] dcap [4096];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++) begin
        m_wall[r][c] = 1'b0;
        m_path[r][c] = 1'b0;
      end
    m_count = 0;
    m_err   = 1'b0;
  endtask

  task automatic monitor();
    int er, ec;
    logic [1:0] exp_cell;
    forever begin
      @(negedge clk);
      if (!rst && mon_ready) begin
        checks++;
        if (maze_in !== m_in || path_count !== 13'(m_count) || err_wall_write !== m_err ||
            busy !== 1'b0 || dump_valid !== 1'b0) begin
          failures++;
          $display("FAIL ready_cycle t=%0t maze_in=%b/%b path_count=%0d/%0d err=%b/%b busy=%b dump_valid=%b",
                   $time, maze_in, m_in, path_count, m_count, err_wall_write, m_err, busy, dump_valid);
        end
      end
      if (!rst && mon_dump && dump_valid) begin
        checks++;
        if (d_idx > 4095) begin
          failures++;
          $display("FAIL dump_overrun idx=%0d required_max=4095", d_idx);
        end else begin
          er = d_idx / 64;
          ec = d_idx % 64;
          exp_cell = {m_path[er][ec], m_wall[er][ec]};
          dcap[d_idx] = dump_cell;
          if (dump_row !== 6'(er) || dump_col !== 6'(ec) || dump_cell !== exp_cell ||
              dump_done !== (d_idx == 4095) || busy !== 1'b1) begin
            failures++;
            $display("FAIL dump_cell idx=%0d pos=(%0d,%0d)/(%0d,%0d) cell=%b/%b done=%b busy=%b",
                     d_idx, dump_row, dump_col, er, ec, dump_cell, exp_cell, dump_done, busy);
          end
        end
        if (dump_done) d_done_cnt++;
        d_idx++;
      end
    end
  endtask

  task automatic busy_wait(input string name);
    int n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    check(name, 16'(n), 16'd64);
  endtask

  task automatic do_reset();
    mon_ready = 1'b0;
    mon_dump  = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 16'(busy), 16'd1);
    check("rst_maze_in", 16'(maze_in), 16'd0);
    check("rst_dump_valid", 16'(dump_valid), 16'd0);
    check("rst_dump_bus", {dump_done, dump_cell, dump_row, dump_col}, 16'd0);
    check("rst_path_count", 16'(path_count), 16'd0);
    check("rst_err", 16'(err_wall_write), 16'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    m_in = 1'b0;
    busy_wait("clear_after_rst_cycles");
    mon_ready = 1'b1;
  endtask

  task automatic op(input logic oe, input logic we, input int r, input int c,
                    input logic ld, input int lr, input int lc, input logic lw);
    bit w_pre, p_pre, same;
    maze_oe = oe; maze_we = we; row = 6'(r); col = 6'(c);
    load_en = ld; load_row = 6'(lr); load_col = 6'(lc); load_wall = lw;
    @(posedge clk);
    w_pre = m_wall[r][c];
    p_pre = m_path[r][c];
    same  = ld && lr == r && lc == c;
    if (oe) m_in = w_pre;
    if (we && !same) begin
      if (w_pre) m_err = 1'b1;
      else if (!p_pre) begin
        m_path[r][c] = 1'b1;
        m_count++;
      end
    end
    if (ld) begin
      if (m_path[lr][lc]) m_count--;
      m_wall[lr][lc] = lw;
      m_path[lr][lc] = 1'b0;
    end
    #1;
    maze_oe = 1'b0; maze_we = 1'b0; load_en = 1'b0;
  endtask

  // clr_at: inject clear_req at that valid count (ignored by DUMP); abort_at: assert rst there.
  task automatic run_dump(input int clr_at, input int abort_at, output int nvalid);
    d_idx = 0;
    d_done_cnt = 0;
    nvalid = 0;
    mon_ready = 1'b0;
    mon_dump  = 1'b1;
    dump_req  = 1'b1;
    @(posedge clk);
    #1 dump_req = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (dump_valid) nvalid++;
      else break;
      if (clr_at > 0 && nvalid == clr_at) clear_req = 1'b1;
      if (clr_at > 0 && nvalid == clr_at + 1) clear_req = 1'b0;
      if (abort_at > 0 && nvalid == abort_at + 1) begin
        mon_dump = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_dump_valid", 16'(dump_valid), 16'd0);
        check("abort_busy", 16'(busy), 16'd1);
        check("abort_dump_done", 16'(dump_done), 16'd0);
        return;
      end
    end
    clear_req = 1'b0;
    mon_dump  = 1'b0;
    mon_ready = 1'b1;
  endtask

  initial begin
    int n;
    fork
      monitor();
    join_none

    // Reset, startup clear, full dump of an empty grid
    do_reset();
    run_dump(0, 0, n);
    check("dump_len_empty", 16'(n), 16'd4096);
    check("dump_done_pulses", 16'(d_done_cnt), 16'd1);
    check("dump_first_cell", 16'(dcap[0]), 16'd0);
    check("dump_last_cell", 16'(dcap[4095]), 16'd0);

    // Wall load then back-to-back reads
    op(0, 0, 0, 0, 1, 5, 7, 1);
    op(1, 0, 5, 7, 0, 0, 0, 0);
    @(negedge clk);
    check("read_wall_5_7", 16'(maze_in), 16'd1);
    op(1, 0, 5, 8, 0, 0, 0, 0);
    @(negedge clk);
    check("read_free_5_8", 16'(maze_in), 16'd0);

    // Path marks, duplicate mark does not count
    op(0, 1, 3, 3, 0, 0, 0, 0);
    op(0, 1, 3, 3, 0, 0, 0, 0);
    op(0, 1, 3, 4, 0, 0, 0, 0);
    @(negedge clk);
    check("path_count_two", 16'(path_count), 16'd2);
    check("model_count_two", 16'(m_count), 16'd2);

    // Mark onto a wall
    op(0, 1, 5, 7, 0, 0, 0, 0);
    @(negedge clk);
    check("wall_write_count", 16'(path_count), 16'd2);
    check("wall_write_err", 16'(err_wall_write), 16'd1);

    // Read and mark together, then reload the cell as wall
    op(1, 1, 10, 10, 0, 0, 0, 0);
    @(negedge clk);
    check("oe_we_maze_in", 16'(maze_in), 16'd0);
    check("oe_we_count", 16'(path_count), 16'd3);
    op(0, 0, 0, 0, 1, 10, 10, 1);
    @(negedge clk);
    check("load_on_path_count", 16'(path_count), 16'd2);

    // Load and mark on the same cell: load wins
    op(0, 1, 20, 20, 1, 20, 20, 0);
    @(negedge clk);
    check("load_vs_we_count", 16'(path_count), 16'd2);

    // Dump with a clear_req mid-stream that must be ignored
    run_dump(10, 0, n);
    check("dump_len_marked", 16'(n), 16'd4096);
    check("dump_3_3", 16'(dcap[3*64+3]), 16'b10);
    check("dump_3_4", 16'(dcap[3*64+4]), 16'b10);
    check("dump_5_7", 16'(dcap[5*64+7]), 16'b01);
    check("dump_10_10", 16'(dcap[10*64+10]), 16'b01);
    check("dump_20_20", 16'(dcap[20*64+20]), 16'b00);
    check("err_kept_after_dump", 16'(err_wall_write), 16'd1);

    op(0, 0, 0, 0, 1, 3, 4, 0);
    @(negedge clk);
    check("load_free_on_path", 16'(path_count), 16'd1);

    // clear_req and dump_req together: clear wins
    mon_ready = 1'b0;
    clear_req = 1'b1;
    dump_req  = 1'b1;
    @(posedge clk);
    model_clear();
    #1;
    clear_req = 1'b0;
    dump_req  = 1'b0;
    busy_wait("clear_wins_cycles");
    mon_ready = 1'b1;
    check("clear_err", 16'(err_wall_write), 16'd0);
    check("clear_count", 16'(path_count), 16'd0);

    // Reset in the middle of a dump
    op(0, 1, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("mark_1_1", 16'(path_count), 16'd1);
    run_dump(0, 100, n);
    check("abort_seen_cells", 16'(n), 16'd101);
    do_reset();
    check("post_abort_count", 16'(path_count), 16'd0);
    op(1, 0, 5, 7, 0, 0, 0, 0);
    @(negedge clk);
    check("post_abort_read_5_7", 16'(maze_in), 16'd0);
    run_dump(0, 0, n);
    check("dump_len_post_abort", 16'(n), 16'd4096);
    check("post_abort_dump_1_1", 16'(dcap[1*64+1]), 16'd0);
    check("post_abort_dump_5_7", 16'(dcap[5*64+7]), 16'd0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maze_memory.md
Name: maze_memory

Overview:
- Responder side of the maze access interface driven by the solver. The solver drives row, col, maze_oe and maze_we; this block returns maze_in.
- Holds a ROWS x COLS grid with a wall bit and a path bit per cell. Answers synchronous reads and records path-mark writes.
- Testbench and host use a cell load port, a clear command and a row-major dump stream to check the solved path.

Parameters:
- ROWS, 64, number of grid rows (at most 64).
- COLS, 64, number of grid columns (at most 64).
- AW, 6, row/column index width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- row  in  AW  solver row select.
- col  in  AW  solver column select.
- maze_oe  in  1  solver read enable, sampled at posedge.
- maze_we  in  1  solver path-mark write enable, sampled at posedge.
- maze_in  out  1  read data: 1 = wall, 0 = free.
- load_en  in  1  host cell write.
- load_row  in  AW  host cell row.
- load_col  in  AW  host cell column.
- load_wall  in  1  wall value written by the host.
- clear_req  in  1  start a grid clear.
- dump_req  in  1  start a grid dump.
- busy  out  1  high in CLEAR or DUMP.
- dump_valid  out  1  dump data valid.
- dump_row  out  AW  row of the dumped cell.
- dump_col  out  AW  column of the dumped cell.
- dump_cell  out  2  {path, wall} of the dumped cell.
- dump_done  out  1  one-cycle pulse on the last dumped cell.
- path_count  out  13  number of distinct free cells marked as path.
- err_wall_write  out  1  sticky flag: a write targeted a wall.

Behaviour:
Reset values:
- rst asynchronously forces: state=CLEAR, clr_row=0, busy=1, maze_in=0, dump_valid=0, dump_done=0, dump_row=0, dump_col=0, dump_cell=0, path_count=0, err_wall_write=0.
- Grid storage has no reset; it is cleared by the CLEAR sweep.

FSM states:
- CLEAR
  - Each cycle, zero wall and path bits of row clr_row, then increment clr_row.
  - After row ROWS-1, go to READY. Takes exactly ROWS cycles.
  - path_count and err_wall_write are zeroed on entry.
- READY
  - busy=0.
  - clear_req → CLEAR. dump_req → DUMP. If both are high, clear wins.
- DUMP
  - Scan row-major from (0,0), one cell per cycle; dump_valid=1.
  - dump_done=1 together with cell (ROWS-1, COLS-1), then go to READY.
  - Total of ROWS*COLS valid cycles. clear_req during DUMP is ignored.

Read path (READY only):
- maze_oe high at edge N → maze_in takes the wall bit of [row][col] at edge N.
- maze_in holds until the next accepted read. Latency is 1 edge.
- row ≥ ROWS or col ≥ COLS reads as wall (1).

Write path (READY only):
- maze_we high sets the path bit of [row][col].
- path_count increments only if the cell was free and not already marked.
- A write to a wall cell, or to an out-of-range cell, leaves the grid unchanged and sets err_wall_write. The flag clears only on CLEAR or rst.

Simultaneous events:
- maze_oe and maze_we on the same cell: maze_in returns the pre-edge wall bit (0 for a free cell) and the path bit is set.
- load_en and maze_we on the same cell in the same cycle: load wins. The wall bit becomes load_wall, the path bit clears, and path_count is not incremented.
- load_en on a cell that already has a path bit: clears the path bit and decrements path_count.

While busy:
- maze_oe, maze_we and load_en are ignored.
- maze_in holds its last value.

Reset mid-operation:
- rst during DUMP or CLEAR aborts immediately (dump_valid drops asynchronously).
- The full CLEAR restarts from row 0.

Decomposition:
- maze_pkg holds:
  - cell encoding: CELL_FREE=2'b00, CELL_WALL=2'b01, CELL_PATH=2'b10;
  - FSM state enum {CLEAR, READY, DUMP};
  - default ROWS/COLS;
  - direction codes (up, right, down, left = 0..3), shared with the solver.
- One sub-module, maze_scan_ctr: the row/column sweep counter used by both CLEAR (row step) and DUMP (cell step). It provides a last-position flag.

Test Plan:
1. Reset release → busy=1 for exactly 64 cycles, then 0. A following dump gives 4096 valid cycles, all dump_cell=2'b00, with dump_done on (63,63).
2. Load wall at (5,7). Read (5,7) at edge N → maze_in=1 after edge N. Read (5,8) at edge N+1 → maze_in=0.
3. maze_we at (3,3) twice plus once at (3,4) → path_count=2. Dump shows (3,3) and (3,4) as 2'b10.
4. maze_we at wall (5,7) → cell still 2'b01, path_count unchanged, err_wall_write=1 until clear_req, after which it reads 0.
5. maze_oe and maze_we on free cell (10,10) in the same cycle → maze_in=0, path set, path_count +1. load_en(10,10, wall=1) next cycle → path_count −1, cell 2'b01.
6. rst asserted at dump cell 100 → dump_valid=0 immediately, busy=1, 64-cycle clear, then grid reads all free and path_count=0.
